// File: rtl/vend_pkg.sv
// Shared constants for the vending session controller: state codes, item codes, default prices.
package vend_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StVend    = 2'd2;
  localparam logic [1:0] StChange  = 2'd3;

  localparam logic [3:0] Item1 = 4'b0001;
  localparam logic [3:0] Item2 = 4'b0010;
  localparam logic [3:0] Item3 = 4'b0100;
  localparam logic [3:0] Item4 = 4'b1000;

  localparam int unsigned DefPrice1  = 3;
  localparam int unsigned DefPrice2  = 4;
  localparam int unsigned DefPrice3  = 5;
  localparam int unsigned DefPrice4  = 6;
  localparam int unsigned DefCreditW = 4;

  localparam int unsigned NickelVal = 1;
  localparam int unsigned DimeVal   = 2;

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle-cycle counter for the COLLECT state; expire is decoded from the registered count.
module vend_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] Last = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != Last)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire = enable && (cnt_q == Last);

endmodule

// File: rtl/vend_session_controller.sv
// One-transaction vending controller: select, collect credit, vend, then return change or refund.
module vend_session_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE1      = DefPrice1,
  parameter int unsigned PRICE2      = DefPrice2,
  parameter int unsigned PRICE3      = DefPrice3,
  parameter int unsigned PRICE4      = DefPrice4,
  parameter int unsigned CREDIT_W    = DefCreditW,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [3:0]          item_number,
  input  logic                item_valid,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                cancel,
  output logic                busy,
  output logic                dispense,
  output logic [3:0]          dispensed_item,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit
);

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [3:0]          item_q, item_d;
  logic                coin_reject_q, coin_reject_d;
  logic [CREDIT_W-1:0] coin_val, credit_sum, price;
  logic                coin, sel_ok, expire, timer_clear, timer_en;

  assign coin       = nickel_in | dime_in;
  assign coin_val   = (nickel_in ? CREDIT_W'(NickelVal) : '0) + (dime_in ? CREDIT_W'(DimeVal) : '0);
  assign credit_sum = credit_q + coin_val;
  assign sel_ok     = item_valid && (item_number != 4'd0) &&
                      ((item_number & (item_number - 4'd1)) == 4'd0);

  always_comb begin
    case (item_q)
      Item1:   price = CREDIT_W'(PRICE1);
      Item2:   price = CREDIT_W'(PRICE2);
      Item3:   price = CREDIT_W'(PRICE3);
      Item4:   price = CREDIT_W'(PRICE4);
      default: price = '0;
    endcase
  end

  // Count only idle COLLECT cycles; any accepted coin restarts the window.
  assign timer_en    = (state_q == StCollect);
  assign timer_clear = !timer_en || coin;

  vend_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    coin_reject_d = coin && (state_q != StCollect);
    case (state_q)
      StIdle: begin
        if (sel_ok) begin
          state_d = StCollect;
          item_d  = item_number;
        end
      end
      StCollect: begin
        if (coin) credit_d = credit_sum;
        // A price-completing coin beats a simultaneous cancel or timeout.
        if (coin && (credit_sum >= price)) begin
          state_d = StVend;
        end else if (cancel || expire) begin
          state_d = (credit_sum != '0) ? StChange : StIdle;
        end
      end
      StVend: begin
        credit_d = credit_q - price;
        state_d  = (credit_d != '0) ? StChange : StIdle;
      end
      StChange: begin
        credit_d = credit_q - CREDIT_W'(1);
        if (credit_q == CREDIT_W'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      item_q        <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_q        <= item_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign dispense       = (state_q == StVend);
  assign dispensed_item = dispense ? item_q : 4'd0;
  assign nickel_out     = (state_q == StChange);
  assign coin_reject    = coin_reject_q;
  assign credit         = credit_q;

endmodule

// File: tb/tb_vend_session_controller.sv
// Directed and random checks of vend_session_controller against a transaction-level model.
module tb_vend_session_controller;

  localparam int unsigned TO = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] item_number;
  logic       item_valid, nickel_in, dime_in, cancel;
  logic       busy, dispense, nickel_out, coin_reject;
  logic [3:0] dispensed_item;
  logic [3:0] credit;

  vend_session_controller #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .item_number   (item_number),
    .item_valid    (item_valid),
    .nickel_in     (nickel_in),
    .dime_in       (dime_in),
    .cancel        (cancel),
    .busy          (busy),
    .dispense      (dispense),
    .dispensed_item(dispensed_item),
    .nickel_out    (nickel_out),
    .coin_reject   (coin_reject),
    .credit        (credit)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int disp_cnt = 0;
  int nout_cnt = 0;

  // Model: which item is chosen, how much credit is held, and what the machine owes.
  int price_tab[4] = '{3, 4, 5, 6};
  int m_item, m_credit, m_idle;
  bit m_sel, m_vend, m_ret, m_rej;

  task automatic model_reset();
    m_item = 0; m_credit = 0; m_idle = 0;
    m_sel = 0; m_vend = 0; m_ret = 0; m_rej = 0;
  endtask

  task automatic model_step(input logic iv, input logic [3:0] it, input logic n, input logic d,
                            input logic c);
    int coins, ones, idx;
    bit timed_out;
    coins = int'(n) + 2 * int'(d);
    ones = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (it[i]) begin ones++; idx = i + 1; end
    m_rej = (n || d) && !m_sel;
    if (m_sel) begin
      timed_out = (m_idle == TO - 1);
      m_idle = (coins != 0) ? 0 : m_idle + 1;
      m_credit += coins;
      if (coins != 0 && m_credit >= price_tab[m_item-1]) begin
        m_sel = 0; m_vend = 1;
      end else if (c || timed_out) begin
        m_sel = 0; m_ret = (m_credit > 0);
      end
    end else if (m_vend) begin
      m_credit -= price_tab[m_item-1];
      m_vend = 0; m_ret = (m_credit > 0);
    end else if (m_ret) begin
      m_credit--;
      m_ret = (m_credit != 0);
    end else if (iv && ones == 1) begin
      m_sel = 1; m_item = idx; m_idle = 0;
    end
  endtask

  function automatic logic [11:0] expected();
    logic [3:0] ditem;
    ditem = m_vend ? 4'(1 << (m_item - 1)) : 4'd0;
    return {(m_sel || m_vend || m_ret), m_vend, ditem, m_ret, m_rej, 4'(m_credit)};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check(tag, {busy, dispense, dispensed_item, nickel_out, coin_reject, credit}, expected());
  endtask

  task automatic cyc(input string tag, input logic iv, input logic [3:0] it, input logic n,
                     input logic d, input logic c);
    item_valid = iv; item_number = it; nickel_in = n; dime_in = d; cancel = c;
    @(posedge clock);
    model_step(iv, it, n, d, c);
    #1;
    disp_cnt += int'(dispense);
    nout_cnt += int'(nickel_out);
    check_outputs(tag);
  endtask

  task automatic sel(input logic [3:0] it);  cyc("select", 1'b1, it, 1'b0, 1'b0, 1'b0); endtask
  task automatic nick();                     cyc("nickel", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic dime();                     cyc("dime",   1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic canc();                     cyc("cancel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc("idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_counts();
    disp_cnt = 0; nout_cnt = 0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    item_valid = 0; item_number = 0; nickel_in = 0; dime_in = 0; cancel = 0;
    model_reset();
    #1;
    check({tag, "_async"}, {busy, dispense, dispensed_item, nickel_out, coin_reject, credit}, 12'd0);
    @(posedge clock);
    #1;
    check_outputs({tag, "_hold"});
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int pct;
    logic iv, n, d, c;
    logic [3:0] it;

    model_reset();
    reset_n = 1'b0;
    item_valid = 0; item_number = 0; nickel_in = 0; dime_in = 0; cancel = 0;
    #3;
    check("reset", {busy, dispense, dispensed_item, nickel_out, coin_reject, credit}, 12'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;

    // Exact pay
    clr_counts();
    sel(4'b0001); nick(); dime(); idle(3);
    check("exact_disp", 12'(disp_cnt), 12'd1);
    check("exact_nout", 12'(nout_cnt), 12'd0);

    // Overpay by one nickel
    clr_counts();
    sel(4'b0010); dime(); nick(); dime(); idle(4);
    check("over_disp", 12'(disp_cnt), 12'd1);
    check("over_nout", 12'(nout_cnt), 12'd1);

    // Cancel with credit, then cancel with none
    clr_counts();
    sel(4'b1000); dime(); dime(); canc(); idle(6);
    check("cancel_disp", 12'(disp_cnt), 12'd0);
    check("cancel_nout", 12'(nout_cnt), 12'd4);
    clr_counts();
    sel(4'b1000); canc(); idle(2);
    check("cancel0_nout", 12'(nout_cnt), 12'd0);

    // Timeout refund, then a coin just before expiry restarting the window
    clr_counts();
    sel(4'b0100); nick(); idle(TO + 3);
    check("timeout_nout", 12'(nout_cnt), 12'd1);
    clr_counts();
    sel(4'b0100); nick(); idle(TO - 2); nick(); idle(TO - 1);
    check("restart_nout", 12'(nout_cnt), 12'd0);
    idle(5);
    check("restart_refund", 12'(nout_cnt), 12'd2);

    // Corner cases
    clr_counts();
    sel(4'b0001); cyc("nick_dime", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0); idle(3);
    check("both_disp", 12'(disp_cnt), 12'd1);
    check("both_nout", 12'(nout_cnt), 12'd0);
    clr_counts();
    sel(4'b0010); dime(); cyc("dime_cancel", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1); idle(3);
    check("vend_wins", 12'(disp_cnt), 12'd1);
    sel(4'b1000); dime(); canc(); nick(); idle(4);
    cyc("bad_item", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0); idle(2);

    // Reset mid-COLLECT and mid-CHANGE
    sel(4'b1000); dime();
    async_reset("rst_collect");
    clr_counts();
    idle(4);
    check("rst_collect_quiet", 12'(nout_cnt), 12'd0);
    sel(4'b1000); dime(); dime(); canc(); idle(1);
    async_reset("rst_change");
    clr_counts();
    idle(6);
    check("rst_change_quiet", 12'(nout_cnt), 12'd0);

    // Random traffic, varying coin density so timeouts also occur
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 3;
          1:       pct = 25;
          default: pct = 45;
        endcase
      end
      iv = ($urandom_range(0, 7) == 0);
      it = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      n  = ($urandom_range(0, 99) < pct);
      d  = ($urandom_range(0, 99) < pct);
      c  = ($urandom_range(0, 39) == 0);
      cyc("random", iv, it, n, d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
